iencoder: RTL
=============

# iencoder

Instruction encoder and program loader for the ARM32CPU instruction memory. It accepts one instruction per handshake as decoded fields: the same field set and internal 7-bit opcode values the instruction decoder produces. It re-packs them into a 32-bit ARM word and writes that word into instruction memory at an auto-incrementing address. On request it terminates the program with a HALT word. It sits between the test/boot host and the instruction RAM, and is the encode-side counterpart of the core's decoder.

## Interface
- ADDR_W, 8, instruction-memory address width
- DEPTH, 256, memory words available; DEPTH <= 2^ADDR_W, DEPTH >= 2
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse: clear address/flags, enter RUN
- finish  input  1  request terminating HALT write
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder accepts bundle this cycle
- sys  input  1  opcode 7'h00/7'h01 mean NOP/HALT instead of register ADD/SUB
- cond  input  4  condition field
- opcode  input  7  internal opcode (decoder encoding)
- en_status  input  1  S bit for data ops
- rn, rd, rs, rm  input  4 each  register fields
- shift_op  input  2  shift type
- imm5  input  5  shift amount (register form)
- imm12  input  12  immediate operand
- imm24  input  24  branch offset
- mem_we  output  1  write strobe to instruction RAM
- mem_addr  output  ADDR_W  write address
- mem_wdata  output  32  encoded instruction
- done  output  1  HALT written, program complete
- err  output  1  sticky: an unencodable opcode was received

## Operation
- States: IDLE (reset), RUN, FIN, DONE. IDLE/DONE --start--> RUN. RUN --finish--> FIN. FIN --HALT write--> DONE. start in any state -> RUN.
- in_ready = (state==RUN) && (wr_ptr < DEPTH-1) && !finish_pending; the last slot is reserved for HALT.
- Handshake completes when in_valid && in_ready. The bundle is encoded into the output register. An unencodable bundle is consumed but not written.
- ALU index alu4 from opcode[3:0]: 0 ADD=0100, 1 SUB=0010, 2 CMP=1010, 3 AND=0000, 4 ORR=1100, 5 EOR=0001, 8 MOV=1101.
- Immediate, opcode 7'h10-15,18: {cond,3'b001,alu4,S,rn,rd,imm12}.
- Register-shifted, 7'h20-25,28: {cond,3'b000,alu4,S,rn,rd,rs,1'b0,shift_op,1'b1,rm}.
- Register, 7'h00-05,08 with sys=0: {cond,3'b000,alu4,S,rn,rd,imm5,shift_op,1'b0,rm}.
- S = en_status; S is forced to 1 for CMP.
- NOP (sys=1, 7'h00): {cond,28'h320F000}. HALT (sys=1, 7'h01): {cond,28'h1000000}.
- B 7'h40: {cond,4'b1010,imm24}. BL 7'h44: {cond,4'b1011,imm24}.
- BX 7'h41: {cond,24'h12FFF1,rm}. BLX 7'h45: {cond,24'h12FFF3,rm}.
- Any other opcode, or sys=1 with opcode not 7'h00/01: err set (sticky until start), no write, wr_ptr unchanged.
- finish is sampled in RUN. If it arrives with an accepted bundle, the bundle is written first, then the HALT at the next address. Terminating HALT uses cond=4'hE.

## Timing
- Reset: state IDLE, wr_ptr 0, mem_we 0, mem_addr 0, mem_wdata 0, done 0, err 0, in_ready 0.
- Latency 1: bundle accepted at edge N gives mem_we=1 for the cycle after N, mem_addr=wr_ptr at acceptance, mem_wdata=encoded word. wr_ptr increments at edge N.
- Throughput one instruction per cycle; mem_we is a single-cycle pulse per word; RAM always accepts.
- FIN: HALT write issued on the first edge in FIN (after any pending bundle write), then DONE on the next edge. done stays high until start.
- Boundary at wr_ptr==DEPTH-1: in_ready low; only finish proceeds.
- start mid-RUN/FIN: an in-flight write is suppressed (mem_we forced 0 next cycle), wr_ptr=0, err=0, done=0. start has priority over finish and in_valid.
- rst_n low at any time returns immediately to reset values, including during a pending write.

## Test plan
- start; push cond=E, op 7'h18, S=0, rd=1, imm12=12'h005 -> mem_we one cycle later, addr 0, wdata 32'hE3A01005.
- push op 7'h00, sys=0, cond=E, S=1, rn=2, rd=3, imm5=4, shift_op=01, rm=5 -> wdata 32'hE0923225; op 7'h02 with S=0 -> S bit still 1.
- B cond=0 imm24=24'hFFFFFE -> 32'h0AFFFFFE; BL -> 32'h0BFFFFFE; BX cond=E rm=14 -> 32'hE12FFF1E, at addresses 0,1,2 back-to-back on consecutive cycles.
- sys=1 op 7'h00 cond=E -> 32'hE320F000 at addr 0. finish with the same handshake -> HALT 32'hE1000000 at addr 1 on the next cycle, done=1, in_ready=0.
- op 7'h30 -> no mem_we, err=1. Next valid bundle is written at the unchanged address. start clears err.
- DEPTH=4: 3 accepted, in_ready drops. finish -> HALT at addr 3, done. start asserted while a write is in flight -> no mem_we, next write at addr 0.

Source files
------------

// File: rtl/iencoder.sv
// ---------------------------------------------------------------------------
// iencoder
//   Instruction encoder and program loader for the ARM32CPU instruction RAM.
//   Takes one decoded field bundle per handshake, using the decoder's field
//   set and its 7-bit internal opcode encoding. Re-packs the bundle into a
//   32-bit ARM word and writes it into instruction memory at an
//   auto-incrementing address. On request it terminates the program with a
//   HALT word placed at the next free address.
//
// Parameters
//   ADDR_W    instruction-memory address width
//   DEPTH     usable memory words (2 <= DEPTH <= 2**ADDR_W); the last word
//             is always kept free for the terminating HALT
//
// Ports
//   clk, rst_n        clock (rising edge) / async active-low reset
//   start             one-cycle pulse: clear address and flags, enter RUN
//   finish            request the terminating HALT write (sampled in RUN)
//   in_valid/in_ready field-bundle handshake
//   sys               opcode 00/01 mean NOP/HALT instead of ADD/SUB (reg)
//   cond..imm24       decoded instruction fields
//   mem_we/addr/wdata instruction-RAM write port (registered, 1-cycle pulse)
//   done              HALT written, program complete (held until start)
//   err               sticky: an unencodable bundle was received
// ---------------------------------------------------------------------------
module iencoder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sys,
    input  logic [3:0]        cond,
    input  logic [6:0]        opcode,
    input  logic              en_status,
    input  logic [3:0]        rn,
    input  logic [3:0]        rd,
    input  logic [3:0]        rs,
    input  logic [3:0]        rm,
    input  logic [1:0]        shift_op,
    input  logic [4:0]        imm5,
    input  logic [11:0]       imm12,
    input  logic [23:0]       imm24,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Highest address; reserved for the terminating HALT.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // Terminating HALT always uses the AL condition.
    localparam logic [31:0] HALT_WORD = {4'hE, 28'h1000000};

    state_t              r_state;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic                r_halt_issued;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic                r_done;
    logic                r_err;

    logic                w_fire;
    logic [3:0]          w_alu4;
    logic                w_alu_ok;
    logic                w_s;
    logic [31:0]         w_word;
    logic                w_ok;

    // No combinational dependence on finish, so a bundle can be accepted in
    // the same cycle that finish is raised.
    assign in_ready = (r_state == S_RUN) && (r_wr_ptr < LAST_ADDR);
    assign w_fire   = in_valid && in_ready;

    // -----------------------------------------------------------------------
    // ALU index -> ARM data-processing opcode field
    // -----------------------------------------------------------------------
    always_comb begin
        w_alu4   = 4'b0000;
        w_alu_ok = 1'b1;
        case (opcode[3:0])
            4'h0:    w_alu4 = 4'b0100; // ADD
            4'h1:    w_alu4 = 4'b0010; // SUB
            4'h2:    w_alu4 = 4'b1010; // CMP
            4'h3:    w_alu4 = 4'b0000; // AND
            4'h4:    w_alu4 = 4'b1100; // ORR
            4'h5:    w_alu4 = 4'b0001; // EOR
            4'h8:    w_alu4 = 4'b1101; // MOV
            default: w_alu_ok = 1'b0;
        endcase
    end

    // CMP only exists to set flags, so its S bit is never left clear.
    assign w_s = en_status || (opcode[3:0] == 4'h2);

    // -----------------------------------------------------------------------
    // Field bundle -> 32-bit ARM word; w_ok low means unencodable
    // -----------------------------------------------------------------------
    always_comb begin
        w_word = 32'h0;
        w_ok   = 1'b0;
        if (sys) begin
            // With sys set only NOP/HALT are meaningful.
            if (opcode == 7'h00) begin
                w_word = {cond, 28'h320F000};
                w_ok   = 1'b1;
            end else if (opcode == 7'h01) begin
                w_word = {cond, 28'h1000000};
                w_ok   = 1'b1;
            end
        end else begin
            case (opcode[6:4])
                3'h0: begin // register operand, immediate shift amount
                    w_word = {cond, 3'b000, w_alu4, w_s, rn, rd,
                              imm5, shift_op, 1'b0, rm};
                    w_ok   = w_alu_ok;
                end
                3'h1: begin // 12-bit immediate operand
                    w_word = {cond, 3'b001, w_alu4, w_s, rn, rd, imm12};
                    w_ok   = w_alu_ok;
                end
                3'h2: begin // register operand shifted by register
                    w_word = {cond, 3'b000, w_alu4, w_s, rn, rd,
                              rs, 1'b0, shift_op, 1'b1, rm};
                    w_ok   = w_alu_ok;
                end
                3'h4: begin // branches
                    case (opcode[3:0])
                        4'h0: begin
                            w_word = {cond, 4'b1010, imm24};
                            w_ok   = 1'b1;
                        end
                        4'h4: begin
                            w_word = {cond, 4'b1011, imm24};
                            w_ok   = 1'b1;
                        end
                        4'h1: begin
                            w_word = {cond, 24'h12FFF1, rm};
                            w_ok   = 1'b1;
                        end
                        4'h5: begin
                            w_word = {cond, 24'h12FFF3, rm};
                            w_ok   = 1'b1;
                        end
                        default: w_ok = 1'b0;
                    endcase
                end
                default: w_ok = 1'b0;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM with registered memory-port outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_halt_issued <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= 32'h0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse unless re-armed below.
            r_mem_we <= 1'b0;
            if (start) begin
                // start overrides finish and any bundle offered this cycle,
                // which also drops a write that would otherwise be issued.
                r_state       <= S_RUN;
                r_wr_ptr      <= '0;
                r_halt_issued <= 1'b0;
                r_done        <= 1'b0;
                r_err         <= 1'b0;
            end else begin
                case (r_state)
                    S_RUN: begin
                        if (w_fire) begin
                            if (w_ok) begin
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= r_wr_ptr;
                                r_mem_wdata <= w_word;
                                r_wr_ptr    <= r_wr_ptr + ADDR_W'(1);
                            end else begin
                                // Consumed, not written; address unchanged.
                                r_err <= 1'b1;
                            end
                        end
                        if (finish)
                            r_state <= S_FIN;
                    end
                    S_FIN: begin
                        // First edge in FIN emits HALT at the next free
                        // address; the following edge declares completion.
                        if (!r_halt_issued) begin
                            r_mem_we      <= 1'b1;
                            r_mem_addr    <= r_wr_ptr;
                            r_mem_wdata   <= HALT_WORD;
                            r_halt_issued <= 1'b1;
                        end else begin
                            r_state       <= S_DONE;
                            r_done        <= 1'b1;
                            r_halt_issued <= 1'b0;
                        end
                    end
                    default: ; // IDLE and DONE wait for start
                endcase
            end
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign done      = r_done;
    assign err       = r_err;

endmodule
